// File: rtl/mem_arbiter.sv
// Arbitrates the shared 4-bank main memory between the I-cache and D-cache.
// Ownership is held for a whole locked sequence and only released once all banks drain.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int NBANK      = 4,
    parameter int HOLD_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_lock,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              i_grant,
    output logic              i_stall,
    output logic [DATA_W-1:0] i_data_out,
    output logic [NBANK-1:0]  i_busy,
    input  logic              d_lock,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    output logic              d_grant,
    output logic              d_stall,
    output logic [DATA_W-1:0] d_data_out,
    output logic [NBANK-1:0]  d_busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data_in,
    output logic              m_rd,
    output logic              m_wr,
    input  logic [DATA_W-1:0] m_data_out,
    input  logic [NBANK-1:0]  m_busy,
    input  logic              m_stall,
    input  logic              m_err,
    output logic              err
);

    localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN_I,
        ST_OWN_D,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;   // 0 = I, 1 = D
    logic              owner_q, owner_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              err_q, err_d;

    logic own_sel, own_lock, own_rd, own_wr, other_lock;

    always_comb begin
        own_sel    = (state_q == ST_OWN_D);
        own_lock   = own_sel ? d_lock : i_lock;
        own_rd     = own_sel ? d_rd   : i_rd;
        own_wr     = own_sel ? d_wr   : i_wr;
        other_lock = own_sel ? i_lock : d_lock;
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        hold_cnt_d   = hold_cnt_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                // On a tie the side that did not own last time wins.
                if (i_lock && (!d_lock || last_owner_q)) begin
                    state_d    = ST_OWN_I;
                    owner_d    = 1'b0;
                    hold_cnt_d = '0;
                end else if (d_lock) begin
                    state_d    = ST_OWN_D;
                    owner_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_OWN_I, ST_OWN_D: begin
                if (other_lock) begin
                    if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_d == HOLD_MAX) err_d = 1'b1;
                end
                if (own_rd && own_wr) err_d = 1'b1;
                if (!own_lock) begin
                    state_d      = ST_DRAIN;
                    last_owner_d = own_sel;
                end
            end
            ST_DRAIN: begin
                if (m_busy == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (m_err) err_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            hold_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            hold_cnt_q   <= hold_cnt_d;
            err_q        <= err_d;
        end
    end

    // Outputs are forced to zero during reset so an in-flight bank result never reaches a cache.
    always_comb begin
        i_grant    = 1'b0;
        i_stall    = 1'b0;
        i_data_out = '0;
        i_busy     = '0;
        d_grant    = 1'b0;
        d_stall    = 1'b0;
        d_data_out = '0;
        d_busy     = '0;
        m_addr     = '0;
        m_data_in  = '0;
        m_rd       = 1'b0;
        m_wr       = 1'b0;
        err        = 1'b0;
        if (!rst) begin
            err     = err_q | m_err;
            i_stall = i_lock;
            d_stall = d_lock;
            case (state_q)
                ST_OWN_I: begin
                    i_grant    = 1'b1;
                    m_rd       = i_rd;
                    m_wr       = i_wr;
                    m_addr     = i_addr;
                    m_data_in  = i_data_in;
                    i_data_out = m_data_out;
                    i_busy     = m_busy;
                    i_stall    = m_stall;
                end
                ST_OWN_D: begin
                    d_grant    = 1'b1;
                    m_rd       = d_rd;
                    m_wr       = d_wr;
                    m_addr     = d_addr;
                    m_data_in  = d_data_in;
                    d_data_out = m_data_out;
                    d_busy     = m_busy;
                    d_stall    = m_stall;
                end
                ST_DRAIN: begin
                    if (owner_q) begin
                        d_data_out = m_data_out;
                        d_busy     = m_busy;
                    end else begin
                        i_data_out = m_data_out;
                        i_busy     = m_busy;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against an ownership-level reference model.
module tb_mem_arbiter;

    localparam int HL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_lock, i_rd, i_wr, d_lock, d_rd, d_wr;
    logic [15:0] i_addr, i_data_in, d_addr, d_data_in;
    logic        i_grant, i_stall, d_grant, d_stall;
    logic [15:0] i_data_out, d_data_out;
    logic [3:0]  i_busy, d_busy;
    logic [15:0] m_addr, m_data_in, m_data_out;
    logic        m_rd, m_wr, m_stall, m_err, err;
    logic [3:0]  m_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who holds the memory (0 none, 1 I, 2 D) and whether it is draining.
    int mdl_own    = 0;
    bit mdl_drain  = 1'b0;
    int mdl_prev   = 2;
    int mdl_wait   = 0;
    bit mdl_sticky = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .NBANK(4), .HOLD_LIMIT(HL)) dut (
        .clk(clk), .rst(rst),
        .i_lock(i_lock), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_data_in(i_data_in),
        .i_grant(i_grant), .i_stall(i_stall), .i_data_out(i_data_out), .i_busy(i_busy),
        .d_lock(d_lock), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_grant(d_grant), .d_stall(d_stall), .d_data_out(d_data_out), .d_busy(d_busy),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
        .m_data_out(m_data_out), .m_busy(m_busy), .m_stall(m_stall), .m_err(m_err),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        bit          act;
        bit          to_i, to_d;
        logic [15:0] e_addr, e_din;
        logic        e_rd, e_wr;
        act  = !rst && mdl_own != 0 && !mdl_drain;
        to_i = !rst && mdl_own == 1;
        to_d = !rst && mdl_own == 2;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_din = '0;
        if (act) begin
            e_rd   = (mdl_own == 1) ? i_rd      : d_rd;
            e_wr   = (mdl_own == 1) ? i_wr      : d_wr;
            e_addr = (mdl_own == 1) ? i_addr    : d_addr;
            e_din  = (mdl_own == 1) ? i_data_in : d_data_in;
        end
        chk("i_grant", i_grant, act && mdl_own == 1);
        chk("d_grant", d_grant, act && mdl_own == 2);
        chk("m_rd", m_rd, e_rd);
        chk("m_wr", m_wr, e_wr);
        chk("m_addr", m_addr, e_addr);
        chk("m_data_in", m_data_in, e_din);
        chk("i_data_out", i_data_out, to_i ? m_data_out : 16'h0);
        chk("d_data_out", d_data_out, to_d ? m_data_out : 16'h0);
        chk("i_busy", i_busy, to_i ? m_busy : 4'h0);
        chk("d_busy", d_busy, to_d ? m_busy : 4'h0);
        chk("i_stall", i_stall, rst ? 1'b0 : (act && mdl_own == 1) ? m_stall : i_lock);
        chk("d_stall", d_stall, rst ? 1'b0 : (act && mdl_own == 2) ? m_stall : d_lock);
        chk("err", err, rst ? 1'b0 : (mdl_sticky | m_err));
    endtask

    task automatic model_step();
        if (rst) begin
            mdl_own = 0; mdl_drain = 0; mdl_prev = 2; mdl_wait = 0; mdl_sticky = 0;
            return;
        end
        if (mdl_own == 0) begin
            if (i_lock && d_lock) mdl_own = (mdl_prev == 1) ? 2 : 1;
            else if (i_lock)      mdl_own = 1;
            else if (d_lock)      mdl_own = 2;
            mdl_wait = 0;
        end else if (!mdl_drain) begin
            if ((mdl_own == 1) ? d_lock : i_lock) begin
                if (mdl_wait < HL) mdl_wait++;
                if (mdl_wait == HL) mdl_sticky = 1;
            end
            if ((mdl_own == 1) ? (i_rd && i_wr) : (d_rd && d_wr)) mdl_sticky = 1;
            if (!((mdl_own == 1) ? i_lock : d_lock)) begin
                mdl_drain = 1;
                mdl_prev  = mdl_own;
            end
        end else if (m_busy == 4'h0) begin
            mdl_own   = 0;
            mdl_drain = 0;
        end
        if (m_err) mdl_sticky = 1;
    endtask

    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0;
        i_lock = 0; i_rd = 0; i_wr = 0; i_addr = '0; i_data_in = '0;
        d_lock = 0; d_rd = 0; d_wr = 0; d_addr = '0; d_data_in = '0;
        m_data_out = '0; m_busy = '0; m_stall = 0; m_err = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        do_reset();
        chk("reset_err", err, 1'b0);
        chk("reset_grant", {i_grant, d_grant}, 2'b00);

        // Single requester: grant one cycle after lock, then forwarding.
        i_lock = 1;
        tick();
        i_rd = 1; i_addr = 16'h0010; m_data_out = 16'hBEEF;
        #1;
        chk("t1_i_grant", i_grant, 1'b1);
        chk("t1_m_rd", m_rd, 1'b1);
        chk("t1_m_addr", m_addr, 16'h0010);
        chk("t1_i_data_out", i_data_out, 16'hBEEF);
        tick();
        i_lock = 0; i_rd = 0;
        repeat (3) tick();

        // Tie from reset goes to I, then D, then I again.
        do_reset();
        i_lock = 1; d_lock = 1;
        tick();
        #1;
        chk("t2_i_first", {i_grant, d_grant}, 2'b10);
        chk("t2_d_waits", d_stall, 1'b1);
        tick();
        i_lock = 0;
        repeat (3) tick();
        #1;
        chk("t2_d_second", {i_grant, d_grant}, 2'b01);
        d_lock = 0;
        tick();
        i_lock = 1; d_lock = 1;
        repeat (2) tick();
        #1;
        chk("t2_i_third", {i_grant, d_grant}, 2'b10);
        i_lock = 0; d_lock = 0;
        repeat (3) tick();

        // Drain held while a bank is still busy; late data still reaches the old owner.
        do_reset();
        d_lock = 1;
        tick();
        d_rd = 1;
        tick();
        d_lock = 0; d_rd = 0; m_busy = 4'b0100;
        tick();
        m_data_out = 16'hCAFE;
        #1;
        chk("t3_drain_m_rd", m_rd, 1'b0);
        chk("t3_drain_data", d_data_out, 16'hCAFE);
        chk("t3_drain_busy", d_busy, 4'b0100);
        chk("t3_drain_grant", d_grant, 1'b0);
        tick();
        m_busy = 4'b0000;
        #1;
        chk("t3_drain2_data", d_data_out, 16'hCAFE);
        tick();
        #1;
        chk("t3_idle_data", d_data_out, 16'h0000);
        tick();

        // Non-owner strobes are ignored.
        d_lock = 1;
        repeat (2) tick();
        i_lock = 1; i_rd = 1;
        #1;
        chk("t4_m_rd", m_rd, 1'b0);
        chk("t4_i_stall", i_stall, 1'b1);
        chk("t4_err", err, 1'b0);
        tick();
        i_lock = 0; i_rd = 0; d_lock = 0;
        repeat (3) tick();

        // Hold timeout sets the sticky error.
        do_reset();
        d_lock = 1;
        tick();
        i_lock = 1;
        for (int k = 0; k < HL - 1; k++) tick();
        #1;
        chk("t5_err_before", err, 1'b0);
        tick();
        #1;
        chk("t5_err_set", err, 1'b1);
        i_lock = 0; d_lock = 0;
        repeat (4) tick();
        #1;
        chk("t5_err_sticky", err, 1'b1);

        // rd&wr from the owner, then reset mid-ownership.
        do_reset();
        d_lock = 1;
        tick();
        d_rd = 1; d_wr = 1;
        tick();
        d_rd = 0; d_wr = 0;
        #1;
        chk("t6_err_rdwr", err, 1'b1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("t6_grant_after_rst", {i_grant, d_grant}, 2'b00);
        chk("t6_err_after_rst", err, 1'b0);
        tick();
        d_lock = 0;
        repeat (3) tick();

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(79) == 0);
            if ($urandom_range(7) == 0) i_lock = ~i_lock;
            if ($urandom_range(7) == 0) d_lock = ~d_lock;
            i_rd       = ($urandom_range(2) == 0);
            i_wr       = !i_rd ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
            d_rd       = ($urandom_range(2) == 0);
            d_wr       = !d_rd ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
            i_addr     = 16'($urandom);
            d_addr     = 16'($urandom);
            i_data_in  = 16'($urandom);
            d_data_in  = 16'($urandom);
            m_data_out = 16'($urandom);
            m_busy     = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
            m_stall    = ($urandom_range(3) == 0);
            m_err      = ($urandom_range(199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
